// File: rtl/sram_arbiter.sv
// Two-master arbiter and strobe sequencer for the external 8-bit asynchronous SRAM.
// Define SRAM_ARB_FIXED_PRIO_EN for fixed priority (m0 wins); the default is round-robin.
//
// state  | meaning
// IDLE   | strobes inactive, waiting for a request; grants and latches the winner
// SETUP  | cs_n low, address valid; write drives data, read asserts oe_n
// ACCESS | WAIT_STATES cycles with we_n (write) or oe_n (read) low
// DONE   | strobes released except cs_n, write data held, ack to the granted master
module sram_arbiter #(
  parameter int ADDR_WIDTH      = 16,
  parameter int SRAM_ADDR_WIDTH = 18,
  parameter int WAIT_STATES     = 2
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_m0_cs,
  input  logic                       i_m1_cs,
  input  logic                       i_m0_we,
  input  logic                       i_m1_we,
  input  logic [ADDR_WIDTH-1:0]      i_m0_addr,
  input  logic [ADDR_WIDTH-1:0]      i_m1_addr,
  input  logic [7:0]                 i_m0_data,
  input  logic [7:0]                 i_m1_data,
  output logic [7:0]                 o_m0_data,
  output logic [7:0]                 o_m1_data,
  output logic                       o_m0_ack,
  output logic                       o_m1_ack,
  output logic [SRAM_ADDR_WIDTH-1:0] o_sram_addr,
  output logic [7:0]                 o_sram_data,
  input  logic [7:0]                 i_sram_data,
  output logic                       o_sram_data_oe,
  output logic                       o_sram_cs_n,
  output logic                       o_sram_we_n,
  output logic                       o_sram_oe_n
);

  localparam int CW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t                     state, state_nxt;
  logic [CW-1:0]              wait_cnt, wait_cnt_nxt;
  logic                       grant, grant_nxt;          // 1 = m1
  logic                       last_grant, last_grant_nxt;
  logic                       we_lat, we_lat_nxt;
  logic [SRAM_ADDR_WIDTH-1:0] addr_nxt;
  logic [7:0]                 wdata_nxt;
  logic [7:0]                 rd_data, rd_data_nxt;
  logic                       m0_ack_nxt, m1_ack_nxt;
  logic                       cs_n_nxt, we_n_nxt, oe_n_nxt, data_oe_nxt;
  logic                       pick_m1;

  assign o_m0_data = rd_data;
  assign o_m1_data = rd_data;

  // Outputs are computed for the state being entered, so every pin comes from a flop.
  always_comb begin
    state_nxt      = state;
    wait_cnt_nxt   = wait_cnt;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    we_lat_nxt     = we_lat;
    addr_nxt       = o_sram_addr;
    wdata_nxt      = o_sram_data;
    rd_data_nxt    = rd_data;
    m0_ack_nxt     = 1'b0;
    m1_ack_nxt     = 1'b0;
    cs_n_nxt       = 1'b1;
    we_n_nxt       = 1'b1;
    oe_n_nxt       = 1'b1;
    data_oe_nxt    = 1'b0;
    pick_m1        = 1'b0;
    case (state)
      IDLE: begin
        if (i_m0_cs || i_m1_cs) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
          pick_m1 = !i_m0_cs;
`else
          pick_m1 = i_m1_cs && (!i_m0_cs || !last_grant);
`endif
          grant_nxt      = pick_m1;
          last_grant_nxt = pick_m1;
          we_lat_nxt     = pick_m1 ? i_m1_we : i_m0_we;
          addr_nxt       = pick_m1 ? SRAM_ADDR_WIDTH'(i_m1_addr) : SRAM_ADDR_WIDTH'(i_m0_addr);
          wdata_nxt      = pick_m1 ? i_m1_data : i_m0_data;
          state_nxt      = SETUP;
          cs_n_nxt       = 1'b0;
          data_oe_nxt    = we_lat_nxt;
          oe_n_nxt       = we_lat_nxt;
        end
      end
      SETUP: begin
        wait_cnt_nxt = CW'(WAIT_STATES - 1);
        state_nxt    = ACCESS;
        cs_n_nxt     = 1'b0;
        we_n_nxt     = !we_lat;
        oe_n_nxt     = we_lat;
        data_oe_nxt  = we_lat;
      end
      ACCESS: begin
        cs_n_nxt    = 1'b0;
        data_oe_nxt = we_lat;
        if (wait_cnt == '0) begin
          state_nxt  = DONE;
          m0_ack_nxt = !grant;
          m1_ack_nxt = grant;
          if (!we_lat)
            rd_data_nxt = i_sram_data;
        end else begin
          wait_cnt_nxt = wait_cnt - CW'(1);
          we_n_nxt     = !we_lat;
          oe_n_nxt     = we_lat;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state          <= IDLE;
      wait_cnt       <= '0;
      grant          <= 1'b0;
      last_grant     <= 1'b1;
      we_lat         <= 1'b0;
      o_sram_addr    <= '0;
      o_sram_data    <= 8'h00;
      rd_data        <= 8'h00;
      o_m0_ack       <= 1'b0;
      o_m1_ack       <= 1'b0;
      o_sram_cs_n    <= 1'b1;
      o_sram_we_n    <= 1'b1;
      o_sram_oe_n    <= 1'b1;
      o_sram_data_oe <= 1'b0;
    end else begin
      state          <= state_nxt;
      wait_cnt       <= wait_cnt_nxt;
      grant          <= grant_nxt;
      last_grant     <= last_grant_nxt;
      we_lat         <= we_lat_nxt;
      o_sram_addr    <= addr_nxt;
      o_sram_data    <= wdata_nxt;
      rd_data        <= rd_data_nxt;
      o_m0_ack       <= m0_ack_nxt;
      o_m1_ack       <= m1_ack_nxt;
      o_sram_cs_n    <= cs_n_nxt;
      o_sram_we_n    <= we_n_nxt;
      o_sram_oe_n    <= oe_n_nxt;
      o_sram_data_oe <= data_oe_nxt;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: WAIT_STATES=2 main instance plus a WAIT_STATES=1 instance.
module tb_sram_arbiter;

  localparam int WS  = 2;
  localparam int PER = 3 + WS;
`ifdef SRAM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  typedef struct packed {
    logic        m;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  data;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_cs = 0, m1_cs = 0, m0_we = 0, m1_we = 0;
  logic [15:0] m0_addr = 0, m1_addr = 0;
  logic [7:0]  m0_wdata = 0, m1_wdata = 0;
  logic [7:0]  m0_rdata, m1_rdata, sram_dout, sram_din;
  logic        m0_ack, m1_ack, sram_doe, cs_n, we_n, oe_n;
  logic [17:0] sram_addr;

  logic        m1_cs_1 = 0;
  logic [15:0] m1_addr_1 = 0;
  logic [7:0]  sram_din_1 = 0;
  logic [7:0]  m0_rdata_1, m1_rdata_1, sram_dout_1;
  logic        m0_ack_1, m1_ack_1, sram_doe_1, cs_n_1, we_n_1, oe_n_1;
  logic [17:0] sram_addr_1;

  int   errors = 0;
  int   checks = 0;
  logic last_m = 1'b1;
  logic [7:0] exp_rd = 8'h00;
  logic [7:0] mem    [0:1023] = '{default: 8'h00};
  logic [7:0] golden [0:1023] = '{default: 8'h00};

  always #20 clk = ~clk;

  sram_arbiter #(.ADDR_WIDTH(16), .SRAM_ADDR_WIDTH(18), .WAIT_STATES(WS)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_m0_cs(m0_cs), .i_m1_cs(m1_cs), .i_m0_we(m0_we), .i_m1_we(m1_we),
    .i_m0_addr(m0_addr), .i_m1_addr(m1_addr), .i_m0_data(m0_wdata), .i_m1_data(m1_wdata),
    .o_m0_data(m0_rdata), .o_m1_data(m1_rdata), .o_m0_ack(m0_ack), .o_m1_ack(m1_ack),
    .o_sram_addr(sram_addr), .o_sram_data(sram_dout), .i_sram_data(sram_din),
    .o_sram_data_oe(sram_doe), .o_sram_cs_n(cs_n), .o_sram_we_n(we_n), .o_sram_oe_n(oe_n)
  );

  sram_arbiter #(.ADDR_WIDTH(16), .SRAM_ADDR_WIDTH(18), .WAIT_STATES(1)) dut1 (
    .i_clk(clk), .i_reset(rst),
    .i_m0_cs(1'b0), .i_m1_cs(m1_cs_1), .i_m0_we(1'b0), .i_m1_we(1'b0),
    .i_m0_addr(16'h0000), .i_m1_addr(m1_addr_1), .i_m0_data(8'h00), .i_m1_data(8'h00),
    .o_m0_data(m0_rdata_1), .o_m1_data(m1_rdata_1), .o_m0_ack(m0_ack_1), .o_m1_ack(m1_ack_1),
    .o_sram_addr(sram_addr_1), .o_sram_data(sram_dout_1), .i_sram_data(sram_din_1),
    .o_sram_data_oe(sram_doe_1), .o_sram_cs_n(cs_n_1), .o_sram_we_n(we_n_1), .o_sram_oe_n(oe_n_1)
  );

  // Asynchronous SRAM pin model
  always @(posedge clk)
    if (!cs_n && !we_n && sram_doe) mem[sram_addr[9:0]] <= sram_dout;
  assign sram_din = mem[sram_addr[9:0]];

  task automatic drive(input logic m, input logic cs, input txn_t t);
    if (!m) begin
      m0_cs = cs; m0_we = t.we; m0_addr = t.addr; m0_wdata = t.data;
    end else begin
      m1_cs = cs; m1_we = t.we; m1_addr = t.addr; m1_wdata = t.data;
    end
  endtask

  // Expected pins {cs_n, we_n, oe_n, data_oe, ack0, ack1} at cycle 'off' after the grant (0 = idle).
  function automatic logic [5:0] exp_bus(input int off, input logic we, input logic m);
    logic act, acc, rd_strobe, done;
    act       = (off >= 1) && (off <= 2 + WS);
    acc       = (off >= 2) && (off <= 1 + WS);
    rd_strobe = !we && (off >= 1) && (off <= 1 + WS);
    done      = (off == 2 + WS);
    return {!act, !(we && acc), !rd_strobe, we && act, done && !m, done && m};
  endfunction

  function automatic txn_t rand_txn(input logic m);
    txn_t t;
    t.m    = m;
    t.we   = 1'($urandom_range(0, 1));
    t.addr = {6'($urandom), 10'($urandom_range(0, 15))};
    t.data = 8'($urandom);
    return t;
  endfunction

  // Runs 'a' (expected winner) then optionally 'b': a contending request if b is the other
  // master, or a back-to-back request with cs held through the ack if it is the same master.
  task automatic run_seq(input txn_t a, input txn_t b, input bit two, input string tag);
    int total, off;
    txn_t t;
    logic [5:0] got, expv;
    total = two ? PER + 2 + WS : 2 + WS;
    drive(a.m, 1'b1, a);
    if (two && b.m != a.m) drive(b.m, 1'b1, b);
    for (int c = 1; c <= total + 1; c++) begin
      @(negedge clk);
      if (c <= 2 + WS) begin off = c; t = a; end
      else if (c > PER && c <= total) begin off = c - PER; t = b; end
      else begin off = 0; t = a; end
      expv = exp_bus(off, t.we, t.m);
      got  = {cs_n, we_n, oe_n, sram_doe, m0_ack, m1_ack};
      checks++;
      if (got !== expv) begin
        errors++;
        $display("FAIL %s bus cycle %0d: got %b want %b", tag, c, got, expv);
      end
      if (off == 1) begin
        checks++;
        if (sram_addr !== {2'b00, t.addr}) begin
          errors++;
          $display("FAIL %s addr: got %h want %h", tag, sram_addr, {2'b00, t.addr});
        end
        if (t.we) begin
          checks++;
          if (sram_dout !== t.data) begin
            errors++;
            $display("FAIL %s wdata: got %h want %h", tag, sram_dout, t.data);
          end
        end
      end
      if (off == 2 + WS) begin
        if (t.we) golden[t.addr[9:0]] = t.data;
        else exp_rd = golden[t.addr[9:0]];
        last_m = t.m;
        checks++;
        if (m0_rdata !== exp_rd || m1_rdata !== exp_rd) begin
          errors++;
          $display("FAIL %s rdata: got %h/%h want %h", tag, m0_rdata, m1_rdata, exp_rd);
        end
      end
      if (c == 2 + WS) begin
        if (two && b.m == a.m) drive(b.m, 1'b1, b);
        else drive(a.m, 1'b0, a);
      end
      if (two && c == total) drive(b.m, 1'b0, b);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({cs_n, we_n, oe_n, sram_doe, m0_ack, m1_ack} !== 6'b111000 || sram_addr !== 18'h0 ||
        sram_dout !== 8'h00 || m0_rdata !== 8'h00 || m1_rdata !== 8'h00) begin
      errors++;
      $display("FAIL reset: bus %b addr %h wd %h rd %h/%h", {cs_n, we_n, oe_n, sram_doe, m0_ack, m1_ack},
               sram_addr, sram_dout, m0_rdata, m1_rdata);
    end
    checks++;
    if ({cs_n_1, we_n_1, oe_n_1, sram_doe_1, m0_ack_1, m1_ack_1} !== 6'b111000 || m1_rdata_1 !== 8'h00) begin
      errors++;
      $display("FAIL reset_ws1: bus %b rd %h", {cs_n_1, we_n_1, oe_n_1, sram_doe_1, m0_ack_1, m1_ack_1}, m1_rdata_1);
    end
    rst = 1'b0;
    last_m = 1'b1;
    exp_rd = 8'h00;
    @(negedge clk);
  endtask

  task automatic test_write();
    txn_t w = '{m: 1'b0, we: 1'b1, addr: 16'h1234, data: 8'hA5};
    run_seq(w, w, 1'b0, "m0_write");
  endtask

  task automatic test_read();
    txn_t r = '{m: 1'b1, we: 1'b0, addr: 16'h1234, data: 8'h00};
    run_seq(r, r, 1'b0, "m1_read");
    checks++;
    if (m1_rdata !== 8'hA5) begin
      errors++;
      $display("FAIL m1_read_value: got %h want a5", m1_rdata);
    end
  endtask

  task automatic test_back_to_back();
    txn_t w = '{m: 1'b0, we: 1'b1, addr: 16'h0203, data: 8'h6E};
    txn_t r = '{m: 1'b0, we: 1'b0, addr: 16'h0203, data: 8'h00};
    run_seq(w, r, 1'b1, "b2b");
  endtask

  task automatic test_round_robin();
    txn_t w = '{m: 1'b0, we: 1'b1, addr: 16'h0300, data: 8'h00};
    txn_t r = '{m: 1'b1, we: 1'b0, addr: 16'h0300, data: 8'h00};
    int cyc, last_ack, n;
    logic exp_w;
    w.addr[3:0] = 4'($urandom);
    r.addr      = w.addr;
    w.data      = 8'($urandom);
    drive(1'b0, 1'b1, w);
    drive(1'b1, 1'b1, r);
    cyc = 0; last_ack = 0; n = 0;
    while (n < 4 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (m0_ack || m1_ack) begin
        exp_w = FIXED ? 1'b0 : !last_m;
        checks++;
        if (m0_ack && m1_ack) begin
          errors++;
          $display("FAIL rr_both_ack at cycle %0d", cyc);
        end
        checks++;
        if (m1_ack !== exp_w) begin
          errors++;
          $display("FAIL rr_order grant %0d: got m1_ack=%b want %b", n, m1_ack, exp_w);
        end
        checks++;
        if (cyc - last_ack != ((n == 0) ? 2 + WS : PER)) begin
          errors++;
          $display("FAIL rr_spacing grant %0d: got %0d want %0d", n, cyc - last_ack, (n == 0) ? 2 + WS : PER);
        end
        if (exp_w) exp_rd = golden[r.addr[9:0]];
        else golden[w.addr[9:0]] = w.data;
        checks++;
        if (m1_rdata !== exp_rd) begin
          errors++;
          $display("FAIL rr_rdata grant %0d: got %h want %h", n, m1_rdata, exp_rd);
        end
        last_m = exp_w;
        last_ack = cyc;
        n++;
      end
    end
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL rr_timeout: got %0d acks want 4", n);
    end
    drive(1'b0, 1'b0, w);
    drive(1'b1, 1'b0, r);
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    txn_t w  = '{m: 1'b0, we: 1'b1, addr: 16'h0055, data: 8'h3C};
    txn_t a  = '{m: 1'b0, we: 1'b0, addr: 16'h0009, data: 8'h00};
    txn_t b  = '{m: 1'b1, we: 1'b1, addr: 16'h000A, data: 8'h00};
    drive(1'b0, 1'b1, w);
    repeat (2) @(negedge clk);
    checks++;
    if (we_n !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_access: we_n got %b want 0", we_n);
    end
    rst = 1'b1;
    drive(1'b0, 1'b0, w);
    @(negedge clk);
    checks++;
    if ({cs_n, we_n, oe_n, sram_doe, m0_ack, m1_ack} !== 6'b111000 || sram_addr !== 18'h0 || m0_rdata !== 8'h00) begin
      errors++;
      $display("FAIL rstmid_abort: bus %b addr %h rd %h", {cs_n, we_n, oe_n, sram_doe, m0_ack, m1_ack}, sram_addr, m0_rdata);
    end
    rst = 1'b0;
    last_m = 1'b1;
    exp_rd = 8'h00;
    for (int i = 0; i < PER; i++) begin
      @(negedge clk);
      checks++;
      if ({cs_n, we_n, oe_n, sram_doe, m0_ack, m1_ack} !== 6'b111000) begin
        errors++;
        $display("FAIL rstmid_quiet cycle %0d: got %b want 111000", i, {cs_n, we_n, oe_n, sram_doe, m0_ack, m1_ack});
      end
    end
    b.data = 8'($urandom);
    run_seq(a, b, 1'b1, "rstmid_recover");
  endtask

  task automatic test_random();
    txn_t x, y;
    logic w;
    int mode;
    for (int i = 0; i < 12; i++) begin
      mode = int'($urandom_range(0, 2));
      if (mode == 0) begin
        x = rand_txn(1'($urandom_range(0, 1)));
        run_seq(x, x, 1'b0, "rand_single");
      end else if (mode == 1) begin
        x = rand_txn(1'b0);
        y = rand_txn(1'b1);
        w = FIXED ? 1'b0 : !last_m;
        if (!w) run_seq(x, y, 1'b1, "rand_contend");
        else run_seq(y, x, 1'b1, "rand_contend");
      end else begin
        w = 1'($urandom_range(0, 1));
        x = rand_txn(w);
        y = rand_txn(w);
        run_seq(x, y, 1'b1, "rand_b2b");
      end
    end
  endtask

  task automatic test_wait1();
    logic [7:0] base, want;
    logic [5:0] got, expv;
    base = 8'($urandom);
    m1_addr_1 = 16'h0007;
    m1_cs_1 = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 4; c++) begin
      #1 sram_din_1 = base + 8'(c);
      @(negedge clk);
      got  = {cs_n_1, we_n_1, oe_n_1, sram_doe_1, m0_ack_1, m1_ack_1};
      expv = (c == 4) ? 6'b111000 : {1'b0, 1'b1, c == 3, 1'b0, 1'b0, c == 3};
      checks++;
      if (got !== expv) begin
        errors++;
        $display("FAIL ws1_bus cycle %0d: got %b want %b", c, got, expv);
      end
      if (c == 3) begin
        want = base + 8'd2;
        checks++;
        if (m1_rdata_1 !== want || m0_rdata_1 !== want) begin
          errors++;
          $display("FAIL ws1_capture: got %h want %h", m1_rdata_1, want);
        end
        m1_cs_1 = 1'b0;
      end
      @(posedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_reset();
    test_round_robin();
    test_reset_mid();
    test_random();
    test_wait1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
Shares the external 8-bit asynchronous SRAM between two bus masters: m0, the UART bus master, and m1, a second on-chip master. The block arbitrates requests and generates the SRAM strobe timing, with a programmable number of access wait states. It returns a one-cycle ack to the granted master. It replaces the tied-high ack path, so masters see real wait states.

Parameters:
ADDR_WIDTH, 16, master address width
SRAM_ADDR_WIDTH, 18, SRAM address width (must be >= ADDR_WIDTH); upper bits zero-extended
WAIT_STATES, 2, cycles in ACCESS state (must be >= 1)

Ports:
i_clk  in  1  system clock (25 MHz domain)
i_reset  in  1  synchronous, active-high reset
i_m0_cs, i_m1_cs  in  1 each  master request
i_m0_we, i_m1_we  in  1 each  1 = write, 0 = read
i_m0_addr, i_m1_addr  in  ADDR_WIDTH each  master address
i_m0_data, i_m1_data  in  8 each  master write data
o_m0_data, o_m1_data  out  8 each  read data (shared read register)
o_m0_ack, o_m1_ack  out  1 each  transaction complete, one-cycle pulse
o_sram_addr  out  SRAM_ADDR_WIDTH  SRAM address
o_sram_data  out  8  data to pad buffers
i_sram_data  in  8  data from pad buffers
o_sram_data_oe  out  1  pad output enable
o_sram_cs_n, o_sram_we_n, o_sram_oe_n  out  1 each  SRAM strobes, active low

Behaviour:
- Interface: one clock (i_clk); reset i_reset is synchronous and active-high.
- All outputs are registered.
- Reset values:
  - FSM = IDLE.
  - cs_n = we_n = oe_n = 1; data_oe = 0.
  - acks = 0; o_sram_addr = 0; o_sram_data = 0; read register = 0.
  - last_grant = m1, so m0 wins the first contention.
- Master handshake:
  - Hold cs, we, addr and data stable until ack.
  - ack is high for exactly one cycle.
  - A cs still high in the cycle after ack is treated as a new request.
- FSM states:
  - IDLE:
    - No request: all strobes inactive, data_oe = 0.
    - One requester: grant it.
    - Both requesting: grant the master not in last_grant (round robin).
    - On grant: latch addr, we and data from the winner; update last_grant; go to SETUP.
  - SETUP (1 cycle):
    - cs_n = 0; address valid.
    - Write: data_oe = 1, we_n = 1, oe_n = 1.
    - Read: oe_n = 0, data_oe = 0.
    - Load wait counter with WAIT_STATES-1; go to ACCESS.
  - ACCESS (WAIT_STATES cycles):
    - Write: we_n = 0.
    - Read: oe_n = 0.
    - Counter decrements; at 0, a read captures i_sram_data into the read register; go to DONE.
  - DONE (1 cycle):
    - we_n = 1; cs_n = 0; write data still driven (hold time).
    - Granted master's ack = 1; go to IDLE.
- Latency: request sampled in IDLE cycle N -> ack high in cycle N+2+WAIT_STATES.
  - Back-to-back from one master: a new access every 3+WAIT_STATES cycles.
- Bus safety: data_oe = 1 only in SETUP/ACCESS/DONE of a write. oe_n and data_oe are never both active.
- Read data: o_m0_data = o_m1_data = read register. Valid while ack is high; holds until the next read completes. A write leaves it unchanged.
- Ungranted requests wait; a grant is never revoked mid-transaction.
- Masters changing cs/addr mid-transaction have no effect; the latched values are used.
- Reset mid-transaction:
  - Next cycle FSM = IDLE with all strobes inactive and data_oe = 0.
  - No ack is issued for the aborted access.
  - last_grant returns to m1.

Optional Feature:
SRAM_ARB_FIXED_PRIO_EN:
- Defined: arbitration is fixed priority; m0 always wins contention, and last_grant is unused.
- Undefined: round-robin as specified above.

Test Plan:
- m0 write addr 0x1234 data 0xA5, WAIT_STATES=2 -> cs_n low 4 cycles, we_n low exactly 2, o_sram_addr=0x01234, o_m0_ack at N+4.
- m1 read 0x1234 with SRAM model returning 0xA5 -> oe_n low 3 cycles, data_oe never 1, o_m1_data=0xA5 with ack, o_m0_ack stays 0.
- Both cs asserted continuously after reset -> grants m0, m1, m0, m1 alternating; every ack at 5-cycle spacing per grant (3+WAIT_STATES) and never simultaneous. With SRAM_ARB_FIXED_PRIO_EN: m0 only.
- Write then immediate read of the same master with cs held high after ack -> second transaction starts from IDLE; data_oe drops before oe_n falls.
- i_reset asserted during ACCESS of a write -> next cycle we_n = cs_n = 1, data_oe = 0, no ack; a following request completes normally with m0 winning contention.
- WAIT_STATES=1 read -> ack at N+3; captured data equals i_sram_data in the last ACCESS cycle.
